// File: rtl/sram_1r1w_pipe_pkg.sv
// Shared definitions for the 1R1W pipelined SRAM: lane arithmetic and
// read-during-write policy encodings.
`ifndef TD
`define TD
`endif

package sram_1r1w_pipe_pkg;

  localparam int RAW_OLD = 0;
  localparam int RAW_NEW = 1;

  function automatic int lane_count(input int word_size, input int lane_width);
    return word_size / lane_width;
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Valid/data delay line behind the SRAM read stage; data only advances with a
// valid beat so the tail holds the last result through idle cycles.
module sram_read_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             head_valid,
  input  logic [WIDTH-1:0] head_data,
  output logic             tail_valid,
  output logic [WIDTH-1:0] tail_data
);

  if (DEPTH == 0) begin : g_passthrough
    logic unused_clocking;
    assign unused_clocking = clk ^ rst_n;
    assign tail_valid      = head_valid;
    assign tail_data       = head_data;
  end else begin : g_stages
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= `TD '0;
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= `TD '0;
        end
      end else begin
        valid_q[0] <= `TD head_valid;
        if (head_valid) data_q[0] <= `TD head_data;
        for (int i = 1; i < DEPTH; i++) begin
          valid_q[i] <= `TD valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= `TD data_q[i-1];
        end
      end
    end

    assign tail_valid = valid_q[DEPTH-1];
    assign tail_data  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/sram_1r1w_pipe.sv
// 1R1W on-chip memory with per-lane write enables, configurable read latency,
// selectable read-during-write policy and output hold.
module sram_1r1w_pipe
  import sram_1r1w_pipe_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int ADDR_SIZE    = 6,
  parameter int LANE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RAW_MODE     = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            write_enable,
  input  logic [ADDR_SIZE-1:0]            write_address,
  input  logic [WORD_SIZE-1:0]            write_data,
  input  logic [WORD_SIZE/LANE_WIDTH-1:0] write_mask,
  input  logic                            read_enable,
  input  logic [ADDR_SIZE-1:0]            read_address,
  output logic [WORD_SIZE-1:0]            read_data,
  output logic                            read_valid
);

  localparam int LANES = lane_count(WORD_SIZE, LANE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_SIZE;

  if (WORD_SIZE % LANE_WIDTH != 0) begin : g_bad_lane_width
    $error("sram_1r1w_pipe: WORD_SIZE must be a multiple of LANE_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_read_latency
    $error("sram_1r1w_pipe: READ_LATENCY must be 1..3");
  end

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] old_word;
  logic [WORD_SIZE-1:0] merged_word;
  logic [WORD_SIZE-1:0] issue_word;
  logic                 collide;
  logic                 s1_valid;
  logic [WORD_SIZE-1:0] s1_data;

  // The array is deliberately not reset; a write on an edge where reset is held is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && write_enable) begin
      for (int i = 0; i < LANES; i++) begin
        if (write_mask[i]) begin
          mem[write_address][i*LANE_WIDTH +: LANE_WIDTH] <= `TD write_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  assign old_word = mem[read_address];
  assign collide  = write_enable && (write_address == read_address);

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (write_mask[i]) begin
        merged_word[i*LANE_WIDTH +: LANE_WIDTH] = write_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  assign issue_word = (RAW_MODE == RAW_NEW && collide) ? merged_word : old_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= `TD 1'b0;
      s1_data  <= `TD '0;
    end else begin
      s1_valid <= `TD read_enable;
      if (read_enable) s1_data <= `TD issue_word;
    end
  end

  sram_read_pipe #(
    .WIDTH (WORD_SIZE),
    .DEPTH (READ_LATENCY - 1)
  ) u_read_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .head_valid (s1_valid),
    .head_data  (s1_data),
    .tail_valid (read_valid),
    .tail_data  (read_data)
  );

endmodule

// File: tb/tb_sram_1r1w_pipe.sv
// Scoreboard bench for sram_1r1w_pipe: four instances (latency 1..3, both
// collision policies) share one stimulus stream and one expected-result queue.
module tb_sram_1r1w_pipe;

  localparam int NDUT = 4;
  localparam int LAT  [NDUT] = '{1, 2, 3, 3};
  localparam int RAWM [NDUT] = '{1, 0, 0, 1};

  typedef struct {
    logic [31:0] old_w;
    logic [31:0] new_w;
    int          issue;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic [3:0]  wm;
  logic        re;
  logic [5:0]  ra;
  logic [31:0] rd [NDUT];
  logic        rv [NDUT];

  exp_t        sb [$];
  int          head [NDUT];
  logic [31:0] last [NDUT];
  logic [31:0] model_mem [64];
  int          cyc;
  int          tests_run;
  int          tests_failed;

  sram_1r1w_pipe #(.WORD_SIZE(32), .ADDR_SIZE(6), .LANE_WIDTH(8), .READ_LATENCY(1), .RAW_MODE(1)) u_l1n (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_address(wa), .write_data(wd), .write_mask(wm),
    .read_enable(re), .read_address(ra), .read_data(rd[0]), .read_valid(rv[0]));
  sram_1r1w_pipe #(.WORD_SIZE(32), .ADDR_SIZE(6), .LANE_WIDTH(8), .READ_LATENCY(2), .RAW_MODE(0)) u_l2o (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_address(wa), .write_data(wd), .write_mask(wm),
    .read_enable(re), .read_address(ra), .read_data(rd[1]), .read_valid(rv[1]));
  sram_1r1w_pipe #(.WORD_SIZE(32), .ADDR_SIZE(6), .LANE_WIDTH(8), .READ_LATENCY(3), .RAW_MODE(0)) u_l3o (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_address(wa), .write_data(wd), .write_mask(wm),
    .read_enable(re), .read_address(ra), .read_data(rd[2]), .read_valid(rv[2]));
  sram_1r1w_pipe #(.WORD_SIZE(32), .ADDR_SIZE(6), .LANE_WIDTH(8), .READ_LATENCY(3), .RAW_MODE(1)) u_l3n (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_address(wa), .write_data(wd), .write_mask(wm),
    .read_enable(re), .read_address(ra), .read_data(rd[3]), .read_valid(rv[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive at the falling edge, update the model for the coming
  // rising edge, then compare every instance against the scoreboard.
  task automatic step(input logic w_en, input logic [5:0] w_a, input logic [31:0] w_d,
                      input logic [3:0] w_m, input logic r_en, input logic [5:0] r_a);
    exp_t e;
    we = w_en; wa = w_a; wd = w_d; wm = w_m; re = r_en; ra = r_a;
    if (rst_n) begin
      if (r_en) begin
        e.old_w = model_mem[r_a];
        e.new_w = e.old_w;
        if (w_en && w_a == r_a) begin
          for (int i = 0; i < 4; i++) if (w_m[i]) e.new_w[i*8 +: 8] = w_d[i*8 +: 8];
        end
        e.issue = cyc;
        sb.push_back(e);
      end
      if (w_en) begin
        for (int i = 0; i < 4; i++) if (w_m[i]) model_mem[w_a][i*8 +: 8] = w_d[i*8 +: 8];
      end
      cyc++;
    end
    @(posedge clk);
    @(negedge clk);
    if (rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        logic        due;
        logic [31:0] want;
        due = 1'b0;
        if (head[d] < sb.size()) due = (sb[head[d]].issue + LAT[d] == cyc);
        want = last[d];
        if (due) want = (RAWM[d] == 1) ? sb[head[d]].new_w : sb[head[d]].old_w;
        tests_run++;
        if (rv[d] !== due) begin
          tests_failed++;
          $display("[TB] FAIL sb_valid dut%0d cyc %0d: got %b want %b", d, cyc, rv[d], due);
        end
        tests_run++;
        if (rd[d] !== want) begin
          tests_failed++;
          $display("[TB] FAIL sb_data dut%0d cyc %0d: got %h want %h", d, cyc, rd[d], want);
        end
        if (due) begin
          last[d] = want;
          head[d]++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 32'd0, 4'd0, 1'b0, 6'd0);
  endtask

  task automatic flush_model();
    sb.delete();
    for (int d = 0; d < NDUT; d++) begin
      head[d] = 0;
      last[d] = 32'd0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int d = 0; d < NDUT; d++) begin
      tests_run++;
      if (rv[d] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_valid dut%0d: got %b want 0", d, rv[d]);
      end
      tests_run++;
      if (rd[d] !== 32'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_data dut%0d: got %h want 00000000", d, rd[d]);
      end
    end
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    step(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 1'b0, 6'd0);
    step(1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd5);
    tests_run++;
    if (rv[1] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_early dut1: got valid %b want 0", rv[1]);
    end
    idle(1);
    tests_run++;
    if (rv[1] !== 1'b1 || rd[1] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL basic_result dut1: got %b/%h want 1/deadbeef", rv[1], rd[1]);
    end
    idle(1);
    tests_run++;
    if (rv[1] !== 1'b0 || rd[1] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL basic_hold dut1: got %b/%h want 0/deadbeef", rv[1], rd[1]);
    end
    idle(2);
  endtask

  task automatic test_masked_write();
    step(1'b1, 6'd3, 32'h11223344, 4'hF, 1'b0, 6'd0);
    step(1'b1, 6'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 6'd0);
    step(1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd3);
    idle(4);
    for (int d = 0; d < NDUT; d++) begin
      tests_run++;
      if (rd[d] !== 32'h11BB33DD) begin
        tests_failed++;
        $display("[TB] FAIL masked_write dut%0d: got %h want 11bb33dd", d, rd[d]);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] want;
    step(1'b1, 6'd7, 32'h00000000, 4'hF, 1'b0, 6'd0);
    step(1'b1, 6'd7, 32'hFFFFFFFF, 4'b0011, 1'b1, 6'd7);
    idle(4);
    for (int d = 0; d < NDUT; d++) begin
      want = (RAWM[d] == 1) ? 32'h0000FFFF : 32'h00000000;
      tests_run++;
      if (rd[d] !== want) begin
        tests_failed++;
        $display("[TB] FAIL collision dut%0d: got %h want %h", d, rd[d], want);
      end
    end
    step(1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd7);
    idle(4);
    for (int d = 0; d < NDUT; d++) begin
      tests_run++;
      if (rd[d] !== 32'h0000FFFF) begin
        tests_failed++;
        $display("[TB] FAIL collision_after dut%0d: got %h want 0000ffff", d, rd[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    k = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 6'(i), 32'(i * 3), 4'hF, 1'b0, 6'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 6'd0, 32'd0, 4'd0, i < 16, 6'(i));
      if (rv[2] === 1'b1) begin
        tests_run++;
        if (rd[2] !== 32'(k * 3) || i != k + 2) begin
          tests_failed++;
          $display("[TB] FAIL b2b_beat %0d at step %0d: got %h want %h at step %0d", k, i, rd[2], k * 3, k + 2);
        end
        k++;
      end
    end
    tests_run++;
    if (k != 16) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got %0d beats want 16", k);
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd1);
    step(1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd2);
    idle(1);
    rst_n = 1'b0;
    flush_model();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      tests_run++;
      if (rv[d] !== 1'b0 || rd[d] !== 32'd0) begin
        tests_failed++;
        $display("[TB] FAIL midflight_reset dut%0d: got %b/%h want 0/00000000", d, rv[d], rd[d]);
      end
    end
    step(1'b1, 6'd1, 32'h00000BAD, 4'hF, 1'b0, 6'd0);
    idle(1);
    rst_n = 1'b1;
    idle(5);
    step(1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd1);
    idle(4);
    for (int d = 0; d < NDUT; d++) begin
      tests_run++;
      if (rd[d] !== 32'd3) begin
        tests_failed++;
        $display("[TB] FAIL midflight_mem dut%0d: got %h want 00000003", d, rd[d]);
      end
    end
  endtask

  task automatic test_write_after_issue();
    step(1'b1, 6'd9, 32'h1, 4'hF, 1'b0, 6'd0);
    step(1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd9);
    step(1'b1, 6'd9, 32'h2, 4'hF, 1'b0, 6'd0);
    step(1'b1, 6'd9, 32'h3, 4'hF, 1'b0, 6'd0);
    idle(4);
    for (int d = 0; d < NDUT; d++) begin
      tests_run++;
      if (rd[d] !== 32'h1) begin
        tests_failed++;
        $display("[TB] FAIL write_after_issue dut%0d: got %h want 00000001", d, rd[d]);
      end
    end
    step(1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd9);
    idle(4);
    for (int d = 0; d < NDUT; d++) begin
      tests_run++;
      if (rd[d] !== 32'h3) begin
        tests_failed++;
        $display("[TB] FAIL write_then_read dut%0d: got %h want 00000003", d, rd[d]);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    we = 1'b0; wa = '0; wd = '0; wm = '0; re = 1'b0; ra = '0;
    flush_model();
    test_reset();
    test_basic();
    test_masked_write();
    test_collision();
    test_back_to_back();
    test_reset_midflight();
    test_write_after_issue();
    for (int d = 0; d < NDUT; d++) begin
      tests_run++;
      if (head[d] != sb.size()) begin
        tests_failed++;
        $display("[TB] FAIL drain dut%0d: got %0d results want %0d", d, head[d], sb.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
